// File: rtl/jtag_board_dr.sv
// rtl/jtag_board_dr.sv - JTAG data-register bank: shared 8-bit capture/shift/update register and chess-core config fields
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   insn                        current TAP instruction (selects the data register)
//   tdi, capture, shift, update TAP user-side scan controls (1-cycle pulses)
//   tdo                         scan output, LSB of the shift register
//   sq_addr, sq_rd_data         square read port (board answers combinationally)
//   sq_wr_en, sq_wr_data        square write strobe and data
//   brd_rd_data                 read-only board status
//   state_mode .. core_sel      configuration fields written by update
//   cfg_updated                 1-cycle pulse after any read/write register update
module jtag_board_dr #(
    parameter int CORE_BITS = 3,
    parameter bit RESET_WTM = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [7:0]           insn,
    input  logic                 tdi,
    input  logic                 capture,
    input  logic                 shift,
    input  logic                 update,
    output logic                 tdo,
    output logic [5:0]           sq_addr,
    input  logic [4:0]           sq_rd_data,
    output logic                 sq_wr_en,
    output logic [4:0]           sq_wr_data,
    input  logic [7:0]           brd_rd_data,
    output logic [2:0]           state_mode,
    output logic [1:0]           mask_mode,
    output logic                 white_to_move,
    output logic [3:0]           write_bus,
    output logic [6:0]           ss1,
    output logic [6:0]           ss2,
    output logic [CORE_BITS-1:0] core_sel,
    output logic                 cfg_updated
);

    localparam logic [3:0] CORE_LEN = 4'(CORE_BITS);

    logic [7:0]           r_sr;
    logic                 r_sq_wr_en;
    logic [4:0]           r_sq_wr_data;
    logic [2:0]           r_state_mode;
    logic [1:0]           r_mask_mode;
    logic                 r_white_to_move;
    logic [3:0]           r_write_bus;
    logic [6:0]           r_ss1;
    logic [6:0]           r_ss2;
    logic [CORE_BITS-1:0] r_core_sel;
    logic                 r_cfg_updated;

    logic [3:0] w_len;
    logic       w_is_sq;
    logic       w_is_none;
    logic [7:0] w_mask;
    logic [7:0] w_cap;
    logic [7:0] w_shift_next;

    // Instruction decode: register length and class
    always_comb begin
        w_len     = 4'd1;
        w_is_sq   = 1'b0;
        w_is_none = 1'b0;
        if (insn >= 8'd1 && insn <= 8'd64) begin
            w_len   = 4'd5;
            w_is_sq = 1'b1;
        end else begin
            case (insn)
                8'd65:        w_len = 4'd3;
                8'd66:        w_len = 4'd2;
                8'd67:        w_len = 4'd1;
                8'd68:        w_len = 4'd4;
                8'd69, 8'd70: w_len = 4'd7;
                8'd71:        w_len = 4'd8;
                8'd72:        w_len = CORE_LEN;
                default:      w_is_none = 1'b1;
            endcase
        end
    end

    assign w_mask = 8'hFF >> (4'd8 - w_len);

    // Capture source, zero-extended to the register width
    always_comb begin
        w_cap = 8'h00;
        if (w_is_sq) begin
            w_cap[4:0] = sq_rd_data;
        end else begin
            case (insn)
                8'd65: w_cap[2:0] = r_state_mode;
                8'd66: w_cap[1:0] = r_mask_mode;
                8'd67: w_cap[0]   = r_white_to_move;
                8'd68: w_cap[3:0] = r_write_bus;
                8'd69: w_cap[6:0] = r_ss1;
                8'd70: w_cap[6:0] = r_ss2;
                8'd71: w_cap      = brd_rd_data;
                8'd72: w_cap[CORE_BITS-1:0] = r_core_sel;
                default: w_cap = 8'h00;
            endcase
        end
    end

    // LSB-first shift: tdi enters at bit len-1, bits above the length stay 0
    always_comb begin
        w_shift_next = ((r_sr >> 1) | ({7'b0, tdi} << (w_len - 4'd1))) & w_mask;
        if (w_is_none) begin
            w_shift_next = 8'h00;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sr            <= 8'h00;
            r_sq_wr_en      <= 1'b0;
            r_sq_wr_data    <= 5'd0;
            r_state_mode    <= 3'd0;
            r_mask_mode     <= 2'd0;
            r_white_to_move <= RESET_WTM;
            r_write_bus     <= 4'd0;
            r_ss1           <= 7'd0;
            r_ss2           <= 7'd0;
            r_core_sel      <= '0;
            r_cfg_updated   <= 1'b0;
        end else begin
            r_sq_wr_en    <= 1'b0;
            r_cfg_updated <= 1'b0;
            if (capture) begin
                r_sr <= w_cap;
            end else if (shift) begin
                r_sr <= w_shift_next;
            end else if (update) begin
                if (w_is_sq) begin
                    r_sq_wr_en    <= 1'b1;
                    r_sq_wr_data  <= r_sr[4:0];
                    r_cfg_updated <= 1'b1;
                end else begin
                    case (insn)
                        8'd65: begin r_state_mode    <= r_sr[2:0]; r_cfg_updated <= 1'b1; end
                        8'd66: begin r_mask_mode     <= r_sr[1:0]; r_cfg_updated <= 1'b1; end
                        8'd67: begin r_white_to_move <= r_sr[0];   r_cfg_updated <= 1'b1; end
                        8'd68: begin r_write_bus     <= r_sr[3:0]; r_cfg_updated <= 1'b1; end
                        8'd69: begin r_ss1           <= r_sr[6:0]; r_cfg_updated <= 1'b1; end
                        8'd70: begin r_ss2           <= r_sr[6:0]; r_cfg_updated <= 1'b1; end
                        8'd72: begin r_core_sel      <= r_sr[CORE_BITS-1:0]; r_cfg_updated <= 1'b1; end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign tdo           = r_sr[0];
    assign sq_addr       = w_is_sq ? (insn[5:0] - 6'd1) : 6'd0;
    assign sq_wr_en      = r_sq_wr_en;
    assign sq_wr_data    = r_sq_wr_data;
    assign state_mode    = r_state_mode;
    assign mask_mode     = r_mask_mode;
    assign white_to_move = r_white_to_move;
    assign write_bus     = r_write_bus;
    assign ss1           = r_ss1;
    assign ss2           = r_ss2;
    assign core_sel      = r_core_sel;
    assign cfg_updated   = r_cfg_updated;

endmodule
